uart_frame_rx_param: RTL

Parametrised UART frame receiver for host-to-FPGA control, for example DDS parameter loads. It integrates the bit-level receiver, a frame state machine (header, payload, CRC8, tail), inter-byte timeout, and error reporting. A validated payload is presented as one flattened bus that updates atomically, with a single-cycle frame_valid strobe. It sits between the board UART pin and the register/control decode logic.

---
 rtl/uart_frame_rx_param.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_rx_param.sv
// UART frame receiver: bit-level receiver, HEADER/payload/CRC8/TAIL frame FSM,
// inter-byte timeout and error reporting, with an atomically updated payload bus.
module uart_frame_rx_param #(
   parameter int         CLK_FREQ     = 50_000_000,
   parameter int         UART_BPS     = 115200,
   parameter int         PAYLOAD_LEN  = 12,
   parameter logic [7:0] HEADER       = 8'h55,
   parameter logic [7:0] TAIL         = 8'hAA,
   parameter logic [7:0] CRC_POLY     = 8'h07,
   parameter logic [7:0] CRC_INIT     = 8'h00,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst_n,
   input  logic                       uart_rxd,
   output logic [7:0]                 byte_data,
   output logic                       byte_valid,
   output logic [8*PAYLOAD_LEN-1:0]   payload,
   output logic                       frame_valid,
   output logic                       err_crc,
   output logic                       err_tail,
   output logic                       err_frame,
   output logic                       err_timeout,
   output logic                       busy,
   output logic [15:0]                ok_cnt,
   output logic [15:0]                err_cnt
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CNT_W   = $clog2(BPS_CNT + 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BPS_CNT / 2);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BPS_CNT - 1);
   localparam int TMO_MAX = TIMEOUT_BITS * BPS_CNT;
   localparam int TMO_W   = $clog2(TMO_MAX + 1);
   localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TMO_MAX);
   localparam logic [6:0]       LAST_IDX = 7'(PAYLOAD_LEN - 1);

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_WAIT  = 3'd4;

   localparam logic [1:0] ST_HUNT    = 2'd0;
   localparam logic [1:0] ST_PAYLOAD = 2'd1;
   localparam logic [1:0] ST_CRC     = 2'd2;
   localparam logic [1:0] ST_TAIL    = 2'd3;

   // MSB-first CRC8 over one byte, eight unrolled shift/XOR steps.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) c = {c[6:0], 1'b0} ^ CRC_POLY;
         else      c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

   logic                     rxd_meta_r, rxd_sync_r, rxd_prev_r;
   logic [2:0]               rx_state_r;
   logic [CNT_W-1:0]         clk_cnt_r;
   logic [2:0]               bit_idx_r;
   logic [7:0]               shift_r;
   logic [7:0]               byte_data_r;
   logic                     byte_valid_r, err_frame_r;
   logic [1:0]               state_r, state_nxt_s;
   logic [6:0]               idx_r;
   logic [7:0]               crc_r, rx_crc_r;
   logic [8*PAYLOAD_LEN-1:0] shadow_r, payload_r;
   logic                     eval_r, crc_ok_r, tail_ok_r;
   logic [TMO_W-1:0]         tmo_cnt_r;
   logic                     expire_s, good_s, err_ev_s;
   logic                     frame_valid_r, err_crc_r, err_tail_r, err_timeout_r, busy_r;
   logic [15:0]              ok_cnt_r, err_cnt_r;

   // Two-stage synchroniser plus edge history, idling high so reset release is quiet.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rxd_meta_r <= 1'b1;
         rxd_sync_r <= 1'b1;
         rxd_prev_r <= 1'b1;
      end else begin
         rxd_meta_r <= uart_rxd;
         rxd_sync_r <= rxd_meta_r;
         rxd_prev_r <= rxd_sync_r;
      end
   end

   // Bit receiver: mid-bit sampling, glitch rejection and stop-bit check.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_state_r   <= RX_IDLE;
         clk_cnt_r    <= '0;
         bit_idx_r    <= 3'd0;
         shift_r      <= 8'h00;
         byte_data_r  <= 8'h00;
         byte_valid_r <= 1'b0;
         err_frame_r  <= 1'b0;
      end else begin
         byte_valid_r <= 1'b0;
         err_frame_r  <= 1'b0;
         case (rx_state_r)
            RX_IDLE: begin
               clk_cnt_r <= '0;
               bit_idx_r <= 3'd0;
               if (rxd_prev_r && !rxd_sync_r) rx_state_r <= RX_START;
            end
            RX_START: begin
               if (clk_cnt_r == HALF_CNT) begin
                  clk_cnt_r  <= '0;
                  rx_state_r <= rxd_sync_r ? RX_IDLE : RX_DATA;
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (clk_cnt_r == BIT_END) begin
                  clk_cnt_r <= '0;
                  shift_r   <= {rxd_sync_r, shift_r[7:1]};
                  bit_idx_r <= bit_idx_r + 3'd1;
                  if (bit_idx_r == 3'd7) rx_state_r <= RX_STOP;
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (clk_cnt_r == BIT_END) begin
                  clk_cnt_r <= '0;
                  if (rxd_sync_r) begin
                     byte_valid_r <= 1'b1;
                     byte_data_r  <= shift_r;
                     rx_state_r   <= RX_IDLE;
                  end else begin
                     err_frame_r <= 1'b1;
                     rx_state_r  <= RX_WAIT;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_W'(1);
               end
            end
            RX_WAIT: begin
               if (rxd_sync_r) rx_state_r <= RX_IDLE;
            end
            default: rx_state_r <= RX_IDLE;
         endcase
      end
   end

   // A byte arriving in the expiry cycle suppresses the timeout; a framing error takes precedence.
   assign expire_s = busy_r && !byte_valid_r && !err_frame_r && (tmo_cnt_r == TMO_LIM);
   assign good_s   = eval_r && crc_ok_r && tail_ok_r;
   assign err_ev_s = err_frame_r || expire_s || (eval_r && !(crc_ok_r && tail_ok_r));

   // Frame FSM next state, with framing error and timeout aborting to HUNT.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_HUNT:    if (byte_valid_r && byte_data_r == HEADER) state_nxt_s = ST_PAYLOAD; else state_nxt_s = ST_HUNT;
         ST_PAYLOAD: if (byte_valid_r && idx_r == LAST_IDX)     state_nxt_s = ST_CRC;     else state_nxt_s = ST_PAYLOAD;
         ST_CRC:     if (byte_valid_r)                          state_nxt_s = ST_TAIL;    else state_nxt_s = ST_CRC;
         ST_TAIL:    if (byte_valid_r)                          state_nxt_s = ST_HUNT;    else state_nxt_s = ST_TAIL;
         default:    state_nxt_s = ST_HUNT;
      endcase
      if (err_frame_r || expire_s) state_nxt_s = ST_HUNT;
      else                         state_nxt_s = state_nxt_s;
   end

   // Frame datapath: shadow buffer, running CRC, received CRC and end-of-frame verdict.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r   <= ST_HUNT;
         idx_r     <= 7'd0;
         crc_r     <= CRC_INIT;
         rx_crc_r  <= 8'h00;
         shadow_r  <= '0;
         eval_r    <= 1'b0;
         crc_ok_r  <= 1'b0;
         tail_ok_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         eval_r  <= 1'b0;
         case (state_r)
            ST_HUNT: begin
               if (byte_valid_r && byte_data_r == HEADER) begin
                  crc_r <= CRC_INIT;
                  idx_r <= 7'd0;
               end
            end
            ST_PAYLOAD: begin
               if (byte_valid_r) begin
                  crc_r <= crc8_byte(crc_r, byte_data_r);
                  idx_r <= idx_r + 7'd1;
                  for (int k = 0; k < PAYLOAD_LEN; k++) begin
                     if (idx_r == 7'(k)) shadow_r[8*k +: 8] <= byte_data_r;
                  end
               end
            end
            ST_CRC: begin
               if (byte_valid_r) rx_crc_r <= byte_data_r;
            end
            ST_TAIL: begin
               if (byte_valid_r) begin
                  eval_r    <= 1'b1;
                  crc_ok_r  <= (rx_crc_r == crc_r);
                  tail_ok_r <= (byte_data_r == TAIL);
               end
            end
            default: eval_r <= 1'b0;
         endcase
      end
   end

   // Timeout counter: runs only inside a frame, cleared by each received byte.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tmo_cnt_r <= '0;
      end else if (!busy_r || byte_valid_r || expire_s) begin
         tmo_cnt_r <= '0;
      end else begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
   end

   // Registered status: strobes, atomic payload update and saturating counters.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         frame_valid_r <= 1'b0;
         err_crc_r     <= 1'b0;
         err_tail_r    <= 1'b0;
         err_timeout_r <= 1'b0;
         busy_r        <= 1'b0;
         payload_r     <= '0;
         ok_cnt_r      <= 16'h0000;
         err_cnt_r     <= 16'h0000;
      end else begin
         frame_valid_r <= good_s;
         err_crc_r     <= eval_r && !crc_ok_r;
         err_tail_r    <= eval_r && !tail_ok_r;
         err_timeout_r <= expire_s;
         busy_r        <= (state_nxt_s != ST_HUNT);
         if (good_s) payload_r <= shadow_r;
         if (good_s && ok_cnt_r != 16'hFFFF) ok_cnt_r <= ok_cnt_r + 16'd1;
         if (err_ev_s && err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
      end
   end

   assign byte_data   = byte_data_r;
   assign byte_valid  = byte_valid_r;
   assign payload     = payload_r;
   assign frame_valid = frame_valid_r;
   assign err_crc     = err_crc_r;
   assign err_tail    = err_tail_r;
   assign err_frame   = err_frame_r;
   assign err_timeout = err_timeout_r;
   assign busy        = busy_r;
   assign ok_cnt      = ok_cnt_r;
   assign err_cnt     = err_cnt_r;

endmodule
